// File: rtl/fetch_pkg.sv
// Shared types and register-control encodings for the instruction fetch path.
// The FunSel constants are intended for reuse by the rest of the control unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_LO  = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_REQ_HI  = 3'd3,
        ST_LOAD_HI = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    localparam logic [2:0] FS_DEC     = 3'b000;
    localparam logic [2:0] FS_INC     = 3'b001;
    localparam logic [2:0] FS_LOAD    = 3'b010;
    localparam logic [2:0] FS_CLR     = 3'b011;
    localparam logic [2:0] FS_LOAD_LZ = 3'b100;
    localparam logic [2:0] FS_LO      = 3'b101;
    localparam logic [2:0] FS_HI      = 3'b110;
    localparam logic [2:0] FS_SEXT    = 3'b111;

    localparam int unsigned CNT_W = 8;

    function automatic logic is_req(input state_t s);
        return (s == ST_REQ_LO) || (s == ST_REQ_HI);
    endfunction

endpackage

// File: rtl/ir_fetch_sequencer_if.sv
// Byte-wide memory read channel: req/ack handshake with data valid alongside ack.
interface ir_fetch_sequencer_if;

    logic       Mem_Req;
    logic       Mem_Ack;
    logic [7:0] Mem_Data;

    modport master (output Mem_Req, input Mem_Ack, input Mem_Data);
    modport slave  (input Mem_Req, output Mem_Ack, output Mem_Data);

endinterface

// File: rtl/ack_timer.sv
// Wait-state counter for the memory handshake; expired flags the last allowed wait cycle.
module ack_timer
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/ir_fetch_sequencer.sv
// Two-byte instruction fetch: reads low then high byte over the memory channel and
// steers the IR/PC register controls, incrementing PC once per loaded byte.
module ir_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic                        Abort,
    ir_fetch_sequencer_if.master        mem,
    output logic [2:0]                  IR_FunSel,
    output logic                        IR_E,
    output logic [15:0]                 IR_I,
    output logic [2:0]                  PC_FunSel,
    output logic                        PC_E,
    output logic                        Busy,
    output logic                        Done,
    output logic                        Error
);

    state_t     state;
    state_t     state_nx;
    logic [7:0] byte_q;
    logic       in_req;
    logic       take_ack;
    logic       expired;
    logic       timer_clr;
    logic       timer_en;

    assign in_req   = is_req(state);
    assign take_ack = in_req && mem.Mem_Ack && !Abort;

    // Counter idles at zero outside REQ states, so it is already clear on entry to each REQ.
    assign timer_clr = !in_req || Abort || mem.Mem_Ack;
    assign timer_en  = in_req && !mem.Mem_Ack && !expired;

    ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            byte_q <= '0;
        end else if (take_ack) begin
            byte_q <= mem.Mem_Data;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (Start) state_nx = ST_REQ_LO;
            end
            ST_REQ_LO: begin
                if (mem.Mem_Ack)  state_nx = ST_LOAD_LO;
                else if (expired) state_nx = ST_ERR;
            end
            ST_LOAD_LO: state_nx = ST_REQ_HI;
            ST_REQ_HI: begin
                if (mem.Mem_Ack)  state_nx = ST_LOAD_HI;
                else if (expired) state_nx = ST_ERR;
            end
            ST_LOAD_HI: state_nx = ST_DONE;
            ST_DONE:    state_nx = ST_IDLE;
            ST_ERR:     state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
        if (Abort) state_nx = ST_IDLE;
    end

    // Moore decode only: a LOAD cycle already in progress completes even if Abort is high.
    always_comb begin
        IR_FunSel = FS_DEC;
        IR_E      = 1'b0;
        IR_I      = '0;
        PC_FunSel = FS_DEC;
        PC_E      = 1'b0;
        unique case (state)
            ST_LOAD_LO: begin
                IR_FunSel = FS_LO;
                IR_E      = 1'b1;
                IR_I      = {8'h00, byte_q};
                PC_FunSel = FS_INC;
                PC_E      = 1'b1;
            end
            ST_LOAD_HI: begin
                IR_FunSel = FS_HI;
                IR_E      = 1'b1;
                IR_I      = {8'h00, byte_q};
                PC_FunSel = FS_INC;
                PC_E      = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem.Mem_Req = in_req;
    assign Busy        = (state != ST_IDLE);
    assign Done        = (state == ST_DONE);
    assign Error       = (state == ST_ERR);

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Directed bench for ir_fetch_sequencer with behavioural IR/PC registers and a result scoreboard.
module tb_ir_fetch_sequencer;
    import fetch_pkg::*;

    localparam int unsigned TMO = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic [2:0]  IR_FunSel;
    logic        IR_E;
    logic [15:0] IR_I;
    logic [2:0]  PC_FunSel;
    logic        PC_E;
    logic        Busy;
    logic        Done;
    logic        Error;

    ir_fetch_sequencer_if mem_bus ();

    ir_fetch_sequencer #(.TIMEOUT(TMO)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Abort     (Abort),
        .mem       (mem_bus),
        .IR_FunSel (IR_FunSel),
        .IR_E      (IR_E),
        .IR_I      (IR_I),
        .PC_FunSel (PC_FunSel),
        .PC_E      (PC_E),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error)
    );

    always #5 Clock = ~Clock;

    // Downstream IR and PC registers, not reset by the sequencer reset
    logic [15:0] ir_q = 16'h0000;
    logic [15:0] pc_q = 16'h0100;

    always @(posedge Clock) begin
        if (IR_E) begin
            case (IR_FunSel)
                FS_LO:   ir_q[7:0]  <= IR_I[7:0];
                FS_HI:   ir_q[15:8] <= IR_I[7:0];
                FS_LOAD: ir_q       <= IR_I;
                FS_CLR:  ir_q       <= 16'h0000;
                default: ;
            endcase
        end
        if (PC_E) begin
            case (PC_FunSel)
                FS_INC:  pc_q <= pc_q + 16'd1;
                FS_DEC:  pc_q <= pc_q - 16'd1;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        int          kind;  // 0 done, 1 error, 2 aborted
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_ir = 16'h0000;
    logic [15:0] exp_pc = 16'h0100;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic req, input logic busy, input logic done,
                            input logic err, input logic ld, input logic [2:0] irfs,
                            input logic [15:0] iri);
        chk({tag, "_req"},   32'(mem_bus.Mem_Req), 32'(req));
        chk({tag, "_busy"},  32'(Busy),            32'(busy));
        chk({tag, "_done"},  32'(Done),            32'(done));
        chk({tag, "_err"},   32'(Error),           32'(err));
        chk({tag, "_ire"},   32'(IR_E),            32'(ld));
        chk({tag, "_pce"},   32'(PC_E),            32'(ld));
        chk({tag, "_irfs"},  32'(IR_FunSel),       32'(irfs));
        chk({tag, "_pcfs"},  32'(PC_FunSel),       ld ? 32'(FS_INC) : 32'd0);
        chk({tag, "_iri"},   32'(IR_I),            32'(iri));
    endtask

    task automatic pop_result(input string tag);
        exp_t e;
        int   kind_obs;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, 32'({Done, Error}), 32'd0);
            return;
        end
        e = sb.pop_front();
        kind_obs = Done ? 0 : (Error ? 1 : 2);
        chk({tag, "_kind"}, 32'(kind_obs), 32'(e.kind));
        chk({tag, "_ir"},   32'(ir_q),     32'(e.ir));
        chk({tag, "_pc"},   32'(pc_q),     32'(e.pc));
    endtask

    // One fetch from an IDLE cycle; wh<0 means the high byte is never acknowledged.
    task automatic run_fetch(input string name, input logic [7:0] lo, input logic [7:0] hi,
                             input int wl, input int wh, input bit hold, input int abort_cyc,
                             input bit spur);
        int   t_ll, t_rh, t_lh, t_end, last, remaining, phase;
        bit   tmo;
        exp_t e;
        tmo   = (wh < 0);
        t_ll  = 2 + wl;
        t_rh  = 3 + wl;
        t_lh  = tmo ? -1 : 4 + wl + wh;
        t_end = tmo ? 3 + wl + int'(TMO) : 5 + wl + wh;
        last  = (abort_cyc > 0) ? abort_cyc : t_end;
        if (last >= t_ll) begin
            exp_ir[7:0] = lo;
            exp_pc      = exp_pc + 16'd1;
        end
        if (!tmo && last >= t_lh) begin
            exp_ir[15:8] = hi;
            exp_pc       = exp_pc + 16'd1;
        end
        e.ir   = exp_ir;
        e.pc   = exp_pc;
        e.kind = (abort_cyc > 0) ? 2 : (tmo ? 1 : 0);
        sb.push_back(e);

        Start = 1'b1;
        @(posedge Clock); #1;
        if (!hold) Start = 1'b0;
        remaining = wl;
        phase     = 0;
        for (int c = 1; c <= last + 1; c++) begin
            logic        act;
            logic        e_req;
            logic [2:0]  e_irfs;
            logic [15:0] e_iri;
            string       tag;
            tag    = $sformatf("%s_c%0d", name, c);
            act    = (c <= last);
            e_req  = act && ((c < t_ll) || (c >= t_rh && c < (tmo ? t_end : t_lh)));
            e_irfs = !act ? 3'b000 : (c == t_ll) ? FS_LO : (c == t_lh) ? FS_HI : 3'b000;
            e_iri  = (act && c == t_ll) ? {8'h00, lo} : (act && c == t_lh) ? {8'h00, hi} : 16'h0000;
            chk_outs(tag, e_req, act, act && !tmo && c == t_end, act && tmo && c == t_end,
                     e_irfs != 3'b000, e_irfs, e_iri);
            if (Done || Error || (abort_cyc > 0 && c == last + 1)) pop_result(tag);

            Abort = (c == abort_cyc);
            if (mem_bus.Mem_Req) begin
                if (remaining == 0 && (phase == 0 || !tmo)) begin
                    mem_bus.Mem_Ack  = 1'b1;
                    mem_bus.Mem_Data = (phase == 0) ? lo : hi;
                    phase++;
                    remaining = wh;
                end else begin
                    mem_bus.Mem_Ack  = 1'b0;
                    mem_bus.Mem_Data = 8'hEE;
                    if (remaining > 0) remaining--;
                end
            end else begin
                mem_bus.Mem_Ack  = spur;
                mem_bus.Mem_Data = 8'hA5;
            end
            @(posedge Clock); #1;
        end
        Abort           = 1'b0;
        mem_bus.Mem_Ack = 1'b0;
    endtask

    initial begin
        mem_bus.Mem_Ack  = 1'b0;
        mem_bus.Mem_Data = 8'h00;
        #1;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0000);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        chk_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0000);

        run_fetch("zw",    8'h34, 8'h12, 0, 0, 1'b0, 0, 1'b0);
        run_fetch("wait3", 8'hCD, 8'hAB, 3, 3, 1'b0, 0, 1'b1);
        run_fetch("tmo",   8'h56, 8'h99, 1, -1, 1'b0, 0, 1'b1);
        run_fetch("abhi",  8'h78, 8'h9A, 0, 2, 1'b0, 4, 1'b0);
        run_fetch("after", 8'hBC, 8'hDE, 1, 0, 1'b0, 0, 1'b0);
        run_fetch("hold1", 8'h11, 8'h22, 0, 0, 1'b1, 0, 1'b0);
        run_fetch("hold2", 8'h33, 8'h44, 0, 1, 1'b1, 0, 1'b1);
        run_fetch("hold3", 8'h55, 8'h66, 0, 0, 1'b0, 0, 1'b0);
        run_fetch("ablo",  8'h77, 8'h88, 0, 0, 1'b0, 2, 1'b0);

        // Reset pulled mid LOAD_HI: outputs must clear before the next edge
        Start = 1'b1;
        @(posedge Clock); #1;
        Start            = 1'b0;
        mem_bus.Mem_Ack  = 1'b1;
        mem_bus.Mem_Data = 8'h5A;
        @(posedge Clock); #1;
        mem_bus.Mem_Ack = 1'b0;
        chk("rst_ldlo_ire", 32'(IR_E), 32'd1);
        @(posedge Clock); #1;
        mem_bus.Mem_Ack  = 1'b1;
        mem_bus.Mem_Data = 8'hC3;
        chk("rst_reqhi_req", 32'(mem_bus.Mem_Req), 32'd1);
        @(posedge Clock); #1;
        mem_bus.Mem_Ack = 1'b0;
        chk("rst_ldhi_irfs", 32'(IR_FunSel), 32'(FS_HI));
        #2 Reset = 1'b0;
        #1;
        chk_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0000);
        exp_ir[7:0] = 8'h5A;
        exp_pc      = exp_pc + 16'd1;
        @(posedge Clock); #1;
        chk("rst_ir", 32'(ir_q), 32'(exp_ir));
        chk("rst_pc", 32'(pc_q), 32'(exp_pc));
        #2 Reset = 1'b1;
        @(posedge Clock); #1;

        run_fetch("final", 8'hF0, 8'h0F, 2, 0, 1'b0, 0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
